// File: rtl/pkt_switch_pkg.sv
// pkt_switch_pkg: shared types for the packet switch (ingress FSM states, FIFO entry)
package pkt_switch_pkg;

    // Widest supported data word; narrower DATA_W values zero-extend into the entry
    localparam int MAX_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_DROP
    } ing_state_e;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
    } fifo_entry_t;

endpackage

// File: rtl/pkt_fifo.sv
// pkt_fifo: show-ahead ingress FIFO; a write into a full FIFO is taken when a pop frees a slot in the same cycle
module pkt_fifo
    import pkt_switch_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        wr_en,
    input  fifo_entry_t wr_data,
    input  logic        rd_en,
    output fifo_entry_t rd_data,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_wr, do_rd;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        do_rd    = rd_en && count_q != '0;
        do_wr    = wr_en && (count_q != (AW+1)'(DEPTH) || do_rd);
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries covered by count are ever consumed
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;

endmodule

// File: rtl/pkt_switch_np.sv
// pkt_switch_np: NUM_PORTS x NUM_PORTS packet switch with per-input FIFOs and per-output round-robin, packet-locked arbitration.
// Define SWITCH_STATS_EN to add per-egress transmitted-packet counters on outPktCnt.
module pkt_switch_np
    import pkt_switch_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int DEST_LSB   = 0
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] inData,
    input  logic [NUM_PORTS-1:0]             inValid,
    input  logic [NUM_PORTS-1:0]             inSop,
    input  logic [NUM_PORTS-1:0]             inEop,
    output logic [NUM_PORTS-1:0]             inStall,
    output logic [NUM_PORTS-1:0][DATA_W-1:0] outData,
    output logic [NUM_PORTS-1:0]             outValid,
    output logic [NUM_PORTS-1:0]             outSop,
    output logic [NUM_PORTS-1:0]             outEop,
    input  logic [NUM_PORTS-1:0]             portStall,
    output logic [NUM_PORTS-1:0]             errFrame,
    output logic [NUM_PORTS-1:0]             errDest,
    output logic [NUM_PORTS-1:0]             errOvf
`ifdef SWITCH_STATS_EN
    ,output logic [NUM_PORTS-1:0][31:0]      outPktCnt
`endif
);

    localparam int PW = $clog2(NUM_PORTS);
    // One guard bit above the port index so out-of-range destinations are visible for power-of-two NUM_PORTS
    localparam int DW = PW + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    ing_state_e                       st_q [NUM_PORTS], st_d [NUM_PORTS];
    fifo_entry_t                      wr_ent [NUM_PORTS], head [NUM_PORTS];
    logic [AW:0]                      count [NUM_PORTS];
    logic [NUM_PORTS-1:0]             wr_en, pop, full, empty, unused_hi;
    logic [NUM_PORTS-1:0]             err_frame_q, err_frame_d, err_dest_q, err_dest_d, err_ovf_q, err_ovf_d;
    logic [NUM_PORTS-1:0]             lock_q, lock_d;
    logic [PW-1:0]                    owner_q [NUM_PORTS], owner_d [NUM_PORTS];
    logic [PW-1:0]                    rr_q [NUM_PORTS], rr_d [NUM_PORTS];
    logic [NUM_PORTS-1:0][DATA_W-1:0] o_data_q, o_data_d;
    logic [NUM_PORTS-1:0]             o_valid_q, o_valid_d, o_sop_q, o_sop_d, o_eop_q, o_eop_d;
    logic [PW-1:0]                    src, idx;
    logic                             take;
`ifdef SWITCH_STATS_EN
    logic [NUM_PORTS-1:0][31:0]       cnt_q, cnt_d;
`endif

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
        pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .resetN  (resetN),
            .wr_en   (wr_en[i]),
            .wr_data (wr_ent[i]),
            .rd_en   (pop[i]),
            .rd_data (head[i]),
            .count   (count[i]),
            .full    (full[i]),
            .empty   (empty[i])
        );
        assign inStall[i]   = count[i] >= (AW+1)'(FIFO_DEPTH - 1);
        assign unused_hi[i] = ^(head[i].data >> DATA_W);
    end

    // Ingress framing FSMs: decide which words enter the FIFO and flag framing, destination and overflow errors
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            st_d[i]        = st_q[i];
            wr_en[i]       = 1'b0;
            err_frame_d[i] = 1'b0;
            err_dest_d[i]  = 1'b0;
            wr_ent[i]      = '{data: MAX_DATA_W'(inData[i]), sop: st_q[i] == ST_IDLE, eop: inEop[i]};
            if (inValid[i]) begin
                case (st_q[i])
                    ST_IDLE: begin
                        if (!inSop[i]) begin
                            err_frame_d[i] = 1'b1;
                        end else if (int'(inData[i][DEST_LSB +: DW]) >= NUM_PORTS) begin
                            err_dest_d[i] = 1'b1;
                            st_d[i]       = inEop[i] ? ST_IDLE : ST_DROP;
                        end else begin
                            wr_en[i] = 1'b1;
                            st_d[i]  = inEop[i] ? ST_IDLE : ST_PKT;
                        end
                    end
                    ST_PKT: begin
                        wr_en[i]       = 1'b1;
                        err_frame_d[i] = inSop[i];
                        st_d[i]        = inEop[i] ? ST_IDLE : ST_PKT;
                    end
                    default: st_d[i] = inEop[i] ? ST_IDLE : ST_DROP;
                endcase
            end
            err_ovf_d[i] = wr_en[i] && full[i] && !pop[i];
        end
    end

    // Egress arbitration: locked ports drain their owner, free ports grant round-robin from rr onward
    always_comb begin
        pop       = '0;
        lock_d    = lock_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        o_data_d  = o_data_q;
        o_valid_d = o_valid_q;
        o_sop_d   = o_sop_q;
        o_eop_d   = o_eop_q;
        src       = '0;
        idx       = '0;
        take      = 1'b0;
`ifdef SWITCH_STATS_EN
        cnt_d     = cnt_q;
`endif
        for (int p = 0; p < NUM_PORTS; p++) begin
            src  = owner_q[p];
            take = lock_q[p] && !empty[owner_q[p]];
            if (!portStall[p]) begin
                if (!lock_q[p]) begin
                    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                        idx = PW'((int'(rr_q[p]) + k) % NUM_PORTS);
                        if (!empty[idx] && head[idx].sop && head[idx].data[DEST_LSB +: PW] == PW'(p)) begin
                            src  = idx;
                            take = 1'b1;
                        end
                    end
                end
                o_valid_d[p] = take;
                o_sop_d[p]   = take && head[src].sop;
                o_eop_d[p]   = take && head[src].eop;
                if (take) begin
                    pop[src]    = 1'b1;
                    o_data_d[p] = head[src].data[DATA_W-1:0];
                    lock_d[p]   = !head[src].eop;
                    owner_d[p]  = src;
                    rr_d[p]     = lock_q[p] ? rr_q[p] : PW'((int'(src) + 1) % NUM_PORTS);
`ifdef SWITCH_STATS_EN
                    cnt_d[p]    = head[src].eop ? cnt_q[p] + 32'd1 : cnt_q[p];
`endif
                end
            end
        end
    end

    // Ingress state, arbitration state, error pulses and registered egress outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            st_q        <= '{default: ST_IDLE};
            owner_q     <= '{default: '0};
            rr_q        <= '{default: '0};
            lock_q      <= '0;
            o_data_q    <= '0;
            o_valid_q   <= '0;
            o_sop_q     <= '0;
            o_eop_q     <= '0;
            err_frame_q <= '0;
            err_dest_q  <= '0;
            err_ovf_q   <= '0;
`ifdef SWITCH_STATS_EN
            cnt_q       <= '0;
`endif
        end else begin
            st_q        <= st_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            o_data_q    <= o_data_d;
            o_valid_q   <= o_valid_d;
            o_sop_q     <= o_sop_d;
            o_eop_q     <= o_eop_d;
            err_frame_q <= err_frame_d;
            err_dest_q  <= err_dest_d;
            err_ovf_q   <= err_ovf_d;
`ifdef SWITCH_STATS_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign outData  = o_data_q;
    assign outValid = o_valid_q;
    assign outSop   = o_sop_q;
    assign outEop   = o_eop_q;
    assign errFrame = err_frame_q;
    assign errDest  = err_dest_q;
    assign errOvf   = err_ovf_q;
`ifdef SWITCH_STATS_EN
    assign outPktCnt = cnt_q;
`endif

endmodule

// File: doc/pkt_switch_np.md
PKT_SWITCH_NP -- requirements
Module: pkt_switch_np

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, meaning ingress and egress port count (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning words per ingress FIFO (power of 2, at least 4).
REQ-004 SHALL have parameter DEST_LSB, default 0, meaning the LSB of the destination field in the Sop word; the field is clog2(NUM_PORTS) bits wide.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port resetN, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port inData, input, NUM_PORTS x DATA_W: per-port ingress word.
REQ-008 SHALL have ports inValid, inSop and inEop, input, NUM_PORTS each: per-port word qualifier, start-of-packet and end-of-packet.
REQ-009 SHALL have port inStall, output, NUM_PORTS: per-port ingress backpressure.
REQ-010 SHALL have port outData, output, NUM_PORTS x DATA_W: per-port egress word.
REQ-011 SHALL have ports outValid, outSop and outEop, output, NUM_PORTS each: egress qualifier and framing.
REQ-012 SHALL have port portStall, input, NUM_PORTS: per-egress downstream stall.
REQ-013 SHALL have ports errFrame, errDest and errOvf, output, NUM_PORTS each: one-cycle error pulses per ingress port.

Function
REQ-014 Ingress FSM per port SHALL have states IDLE, PKT and DROP, all leaving via inValid&inEop to IDLE.
- IDLE: inValid&inSop with a valid destination -> write word, go to PKT.
- IDLE: inValid&inSop with destination >= NUM_PORTS -> go to DROP, pulse errDest.
- IDLE: inValid without inSop -> discard word, pulse errFrame.
REQ-015 In PKT, an inSop word SHALL be written as plain data and pulse errFrame; inSop&inEop on one word is a legal single-word packet.
REQ-016 In DROP, words SHALL be discarded.
REQ-017 inStall SHALL assert combinationally when FIFO free entries <= 1; the source may present one more word after stall.
REQ-018 A word arriving with the FIFO full SHALL be discarded and pulse errOvf; FSM state SHALL still follow the word's framing.
REQ-019 Each egress port SHALL arbitrate round-robin among ingress FIFOs whose head is a Sop word for that port.
- Search starts after the last granted input.
- Ties resolve to the next index.
REQ-020 A grant SHALL lock the egress port to that input until its Eop word is popped; interleaving of packets SHALL never occur.
REQ-021 Egress outputs SHALL be registered; minimum latency is 2 cycles from ingress acceptance to outValid.
REQ-022 While portStall[p] is high, egress p SHALL hold outData, outSop, outEop and outValid unchanged and pop nothing.
- The stall reaches the register in the same cycle.
REQ-023 An egress port with no packet SHALL drive outValid=0; outData is don't-care.
REQ-024 Simultaneous write and pop on a full FIFO SHALL be legal: the word is accepted and there is no errOvf.
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be clog2(FIFO_DEPTH)+1 bits.
REQ-026 Sustained throughput SHALL be 1 word per cycle per egress port.

Reset
REQ-027 On resetN low, every output SHALL be 0 (inStall=0), the FIFOs empty, the FSMs in IDLE, the locks released and the RR pointers at 0.
REQ-028 Reset mid-packet SHALL discard partial packets; the egress port SHALL NOT emit outEop for them.

Configuration
REQ-029 With SWITCH_STATS_EN defined, output outPktCnt, NUM_PORTS x 32 bits, SHALL count transmitted outEop words per egress port.
- Counting wraps at 2^32 and resets to 0.
REQ-030 Without SWITCH_STATS_EN, outPktCnt and its counters SHALL be absent.

Structure
REQ-031 Package pkt_switch_pkg SHALL hold the ingress FSM state enum and the FIFO entry struct {data, sop, eop}.
REQ-032 Sub-module pkt_fifo SHALL implement the ingress FIFO, with count and full/empty outputs, instantiated NUM_PORTS times.

Verification
REQ-033 Single-word packet on input 0 (0x0000_0002, Sop&Eop) -> egress 2 emits it with outSop=outEop=1, 2 cycles later.
REQ-034 Inputs 0 and 1 both send 4-word packets to egress 3 in the same cycle -> input 0's 4 words, then input 1's 4 words, no interleave; the next contention grants input 1 first.
REQ-035 Destination 5 with NUM_PORTS=4 -> errDest pulse, packet absent at every egress.
REQ-036 portStall[1] held 3 cycles mid-packet -> egress 1 holds the word; the packet completes intact after release.
REQ-037 Source ignores inStall and sends 18 words into FIFO_DEPTH=16 with egress stalled -> inStall after 15 words, errOvf on words 17 and 18.
REQ-038 Reset asserted mid-packet -> all outputs 0; after release, a new packet forwards correctly with no stale outEop.
